// File: rtl/register_file_if.sv
// +----------------------------------------------------------------------------+
// | register_file_if : read/write bus between the core datapath and the         |
// |                    register file.                                           |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

interface register_file_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic [ADDR_WIDTH-1:0] raddr1;
    logic [ADDR_WIDTH-1:0] raddr2;
    logic [DATA_WIDTH-1:0] rdata1;
    logic [DATA_WIDTH-1:0] rdata2;
    logic                  we;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;

    modport master (
        output raddr1, raddr2, we, waddr, wdata,
        input  rdata1, rdata2
    );

    modport slave (
        input  raddr1, raddr2, we, waddr, wdata,
        output rdata1, rdata2
    );
endinterface

`default_nettype wire

// File: rtl/register_file.sv
// +----------------------------------------------------------------------------+
// | register_file : 2**ADDR_WIDTH x DATA_WIDTH register file, two combinational |
// |                 read ports, one write port, r0 hardwired to zero.           |
// | Optional: define REGFILE_DEBUG_PORT_EN to add the dbg_addr/dbg_data port.   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module register_file #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter int WRITE_BYPASS = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    register_file_if.slave        bus
`ifdef REGFILE_DEBUG_PORT_EN
    ,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    output logic [DATA_WIDTH-1:0] dbg_data
`endif
);

    localparam int c_DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_regs [c_DEPTH];
    logic [DATA_WIDTH-1:0] w_stored1;
    logic [DATA_WIDTH-1:0] w_stored2;

    // r_regs[0] is cleared on reset and never written, so it stays a constant zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (bus.we && (bus.waddr != '0)) begin
            r_regs[bus.waddr] <= bus.wdata;
        end
    end

    assign w_stored1 = (bus.raddr1 == '0) ? '0 : r_regs[bus.raddr1];
    assign w_stored2 = (bus.raddr2 == '0) ? '0 : r_regs[bus.raddr2];

    generate
        if (WRITE_BYPASS != 0) begin : g_bypass
            logic w_hit1;
            logic w_hit2;

            // Forwarding is suppressed in reset so both ports read zero.
            assign w_hit1 = rst_n && bus.we && (bus.waddr != '0) && (bus.waddr == bus.raddr1);
            assign w_hit2 = rst_n && bus.we && (bus.waddr != '0) && (bus.waddr == bus.raddr2);

            assign bus.rdata1 = w_hit1 ? bus.wdata : w_stored1;
            assign bus.rdata2 = w_hit2 ? bus.wdata : w_stored2;
        end else begin : g_noBypass
            assign bus.rdata1 = w_stored1;
            assign bus.rdata2 = w_stored2;
        end
    endgenerate

`ifdef REGFILE_DEBUG_PORT_EN
    assign dbg_data = (dbg_addr == '0) ? '0 : r_regs[dbg_addr];
`endif

endmodule

`default_nettype wire

// File: doc/register_file.md
Name: register_file

Overview:
- 32 x 32-bit general-purpose register file for the single-cycle MIPS-style core.
- Sits directly upstream of the ALU and drives its A and B operands from two read ports.
- Accepts one write per clock from the writeback path (ALU result C or memory data).
- Register 0 is hardwired to zero.

Parameters:
- DATA_WIDTH, 32, width of each register and of all data ports.
- ADDR_WIDTH, 5, register index width; depth is 2**ADDR_WIDTH.
- WRITE_BYPASS, 0, 1 = a read of the register being written this cycle returns wdata (write-first); 0 = returns the stored value.

Ports:
- clk  input  1  core clock; writes take effect on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- raddr1  input  ADDR_WIDTH  read port 1 index (rs), drives ALU A.
- raddr2  input  ADDR_WIDTH  read port 2 index (rt), drives ALU B.
- rdata1  output  DATA_WIDTH  contents of register raddr1.
- rdata2  output  DATA_WIDTH  contents of register raddr2.
- we  input  1  write enable.
- waddr  input  ADDR_WIDTH  write index (rd or rt).
- wdata  input  DATA_WIDTH  write data.

Behaviour:
- Reset:
  - rst_n low clears every register to 0 immediately, without waiting for clk.
  - While rst_n is low, rdata1 and rdata2 read 0 and writes are ignored.
  - Deassertion is sampled at clk; the first write is accepted on the first rising edge with rst_n high.
- Reset mid-operation: a write whose edge coincides with rst_n low is discarded.
- Write:
  - On posedge clk with rst_n high, we=1 and waddr!=0: reg[waddr] <= wdata.
  - we=0: no state change.
  - waddr=0: the write is dropped silently; reg[0] stays 0.
- Read:
  - Combinational, zero latency: rdata = reg[raddr], so the single-cycle datapath reads and writes back in the same cycle.
  - raddr=0 always yields 0, independent of any write.
- Simultaneous read and write of the same register (we=1, waddr=raddrN, waddr!=0):
  - WRITE_BYPASS=0: rdataN shows the old value until the edge, then the new value.
  - WRITE_BYPASS=1: rdataN shows wdata combinationally in the same cycle.
  - Both read ports may alias each other and the write port at the same time; each port resolves independently.
- Widths: addresses are never out of range (the full 2**ADDR_WIDTH space is implemented). No X may propagate from unwritten registers, because all are reset.
- No stall or handshake. The block is always ready, and the write commits in exactly one cycle.

Optional Feature:
- Macro: REGFILE_DEBUG_PORT_EN.
- When defined, two extra ports are added:
  - dbg_addr, input, ADDR_WIDTH.
  - dbg_data, output, DATA_WIDTH.
- dbg_data = reg[dbg_addr] combinationally, with no bypass and dbg_addr=0 giving 0. It is used by the board display and the testbench for state inspection.
- The debug port has no effect on the functional ports.
- When not defined, the ports do not exist and no extra read mux is synthesised.

Test Plan:
- Reset: write 0xDEADBEEF to r5, then pulse rst_n low between clock edges -> rdata1 (raddr1=5) reads 0 immediately, before the next posedge.
- Basic write/read: we=1, waddr=7, wdata=0x12345678, one edge, then we=0 -> raddr1=7 and raddr2=7 both read 0x12345678 on following cycles.
- r0 immunity: we=1, waddr=0, wdata=0xFFFFFFFF, one edge -> raddr1=0 reads 0x00000000; no other register changes.
- Same-cycle hazard: r3=0x00000001, then we=1, waddr=3, wdata=0x00000002, raddr1=3 before the edge -> rdata1=0x00000001 with WRITE_BYPASS=0, 0x00000002 with WRITE_BYPASS=1; 0x00000002 after the edge in both cases.
- Write disabled: we=0, waddr=9, wdata=0xAAAAAAAA, several edges -> r9 stays at its prior value (0 after reset).
- Full sweep with ALU check: write i*0x01010101 to r1..r31, read back pairs (ri, r(32-i)) into the ALU add path -> each rdata matches and ALU C equals the expected sum; r0 reads 0 throughout.
